// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding the register file's single write port.
// Merges ALU and memory-unit results and forwards pending values to decode.
module reg_writeback_queue #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] look_a,
  input  logic [ADDR_W-1:0] look_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic [ADDR_W:0]   count,
  output logic              empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = ADDR_W + 1;

  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_wb_en;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  logic [CW-1:0]     w_free;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic [PW-1:0]     w_alu_slot;

  // Free space uses current occupancy only; a same-cycle pop never frees a slot.
  assign w_free     = CW'(DEPTH) - r_count;
  assign mem_ready  = (w_free != '0);
  assign alu_ready  = (w_free >= CW'(2)) || ((w_free != '0) && !mem_valid);
  assign w_mem_push = mem_valid && mem_ready && (mem_dest != '0);
  assign w_alu_push = alu_valid && alu_ready && (alu_dest != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wr_ptr + PW'(w_mem_push);

  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_dest[r_wr_ptr] <= mem_dest;
      r_data[r_wr_ptr] <= mem_data;
    end
    if (w_alu_push) begin
      r_dest[w_alu_slot] <= alu_dest;
      r_data[w_alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_mem_push) + PW'(w_alu_push);
      r_count  <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
      r_wb_en  <= w_pop;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_wb_addr <= r_dest[r_rd_ptr];
        r_wb_data <= r_data[r_rd_ptr];
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; wb stage is oldest.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] ptr);
    logic [DATA_W:0] res;
    logic [PW-1:0]   idx;
    res = '0;
    idx = '0;
    if (ptr != '0) begin
      if (r_wb_en && (r_wb_addr == ptr)) res = {1'b1, r_wb_data};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = r_rd_ptr + PW'(i);
        if ((i < 32'(r_count)) && (r_dest[idx] == ptr)) res = {1'b1, r_data[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {hit_a, fwd_a} = lookup(look_a);
    {hit_b, fwd_b} = lookup(look_b);
  end

  assign wb_en   = r_wb_en;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;
  assign count   = r_count;
  assign empty   = (r_count == '0) && !r_wb_en;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with hand-computed expectations.
module tb_reg_writeback_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, alu_valid;
  logic        mem_ready, alu_ready;
  logic [2:0]  mem_dest, alu_dest, look_a, look_b;
  logic [15:0] mem_data, alu_data;
  logic        wb_en, hit_a, hit_b, empty;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data, fwd_a, fwd_b;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  reg_writeback_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .look_a(look_a), .look_b(look_b), .hit_a(hit_a), .hit_b(hit_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; alu_valid = 1'b0;
    mem_dest = '0; alu_dest = '0; mem_data = '0; alu_data = '0;
  endtask

  logic [18:0] bp_exp [8];
  logic [0:0]  bp_alu_rdy [6];
  logic [3:0]  bp_cnt [6];
  int          bp_idx;

  initial begin
    bp_exp = '{{3'd1, 16'h1000}, {3'd4, 16'h2000}, {3'd1, 16'h1001}, {3'd4, 16'h2001},
               {3'd1, 16'h1002}, {3'd1, 16'h1003}, {3'd1, 16'h1004}, {3'd1, 16'h1005}};
    bp_alu_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bp_cnt     = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    rst_n = 1'b0;
    idle();
    look_a = '0; look_b = '0;
    tick(); tick();
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_alu_ready", alu_ready, 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", empty, 1);

    // Single write
    alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
    #1;
    chk("single_alu_ready", alu_ready, 1);
    tick();
    idle();
    chk("single_count1", count, 1);
    chk("single_wb_en0", wb_en, 0);
    chk("single_not_empty", empty, 0);
    tick();
    chk("single_wb_en", wb_en, 1);
    chk("single_wb_addr", wb_addr, 3);
    chk("single_wb_data", wb_data, 16'h1234);
    chk("single_count0", count, 0);
    tick();
    chk("single_wb_en_off", wb_en, 0);
    chk("single_wb_addr_hold", wb_addr, 3);
    chk("single_wb_data_hold", wb_data, 16'h1234);
    chk("single_empty", empty, 1);

    // Dual enqueue ordering
    mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'hBBBB;
    #1;
    chk("dual_mem_ready", mem_ready, 1);
    chk("dual_alu_ready", alu_ready, 1);
    tick();
    idle();
    chk("dual_count2", count, 2);
    tick();
    chk("dual_wb1", {wb_en, wb_addr, wb_data}, {1'b1, 3'd2, 16'hAAAA});
    chk("dual_count1", count, 1);
    tick();
    chk("dual_wb2", {wb_en, wb_addr, wb_data}, {1'b1, 3'd2, 16'hBBBB});
    chk("dual_count0", count, 0);
    tick();
    chk("dual_wb_off", wb_en, 0);
    chk("dual_empty", empty, 1);

    // R0 discard
    alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'hFFFF;
    look_a = 3'd0;
    #1;
    chk("r0_alu_ready", alu_ready, 1);
    chk("r0_hit_a", hit_a, 0);
    chk("r0_fwd_a", fwd_a, 0);
    tick();
    idle();
    chk("r0_count", count, 0);
    chk("r0_wb_en", wb_en, 0);
    chk("r0_empty", empty, 1);
    tick();
    chk("r0_wb_en_later", wb_en, 0);

    // Backpressure: both producers valid for 6 cycles
    bp_idx = 0;
    for (int k = 0; k < 6; k++) begin
      mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h1000 + 16'(k);
      alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h2000 + 16'(k);
      #1;
      chk("bp_mem_ready", mem_ready, 1);
      chk("bp_alu_ready", alu_ready, bp_alu_rdy[k]);
      tick();
      chk("bp_count", count, bp_cnt[k]);
      if (k == 0) chk("bp_wb_idle", wb_en, 0);
      else begin
        chk("bp_wb", {wb_en, wb_addr, wb_data}, {1'b1, bp_exp[bp_idx]});
        bp_idx++;
      end
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_drain", {wb_en, wb_addr, wb_data}, {1'b1, bp_exp[bp_idx]});
      bp_idx++;
    end
    tick();
    chk("bp_done_wb_en", wb_en, 0);
    chk("bp_done_empty", empty, 1);

    // Forwarding
    mem_valid = 1'b1; mem_dest = 3'd5; mem_data = 16'h0000;
    alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h0001;
    look_b = 3'd5; look_a = 3'd2;
    #1;
    chk("fwd_pre_hit_b", hit_b, 0);
    tick();
    idle();
    alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h0002;
    #1;
    chk("fwd_incoming_not_seen", {hit_b, fwd_b}, {1'b1, 16'h0001});
    tick();
    idle();
    #1;
    chk("fwd_wb_stage", {wb_en, wb_addr, wb_data}, {1'b1, 3'd5, 16'h0000});
    chk("fwd_youngest", {hit_b, fwd_b}, {1'b1, 16'h0002});
    chk("fwd_miss_a", {hit_a, fwd_a}, {1'b0, 16'h0000});
    tick();
    chk("fwd_after1", {hit_b, fwd_b}, {1'b1, 16'h0002});
    tick();
    chk("fwd_wb_only", {hit_b, fwd_b}, {1'b1, 16'h0002});
    chk("fwd_wb_only_count", count, 0);
    tick();
    chk("fwd_drained", {hit_b, fwd_b}, {1'b0, 16'h0000});

    // Reset mid-drain
    mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h0A01;
    alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h0A02;
    tick();
    mem_dest = 3'd3; mem_data = 16'h0A03;
    alu_dest = 3'd4; alu_data = 16'h0A04;
    tick();
    idle();
    chk("mid_count3", count, 3);
    chk("mid_wb_en", wb_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb_en", wb_en, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_wb_data", wb_data, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_wb", wb_en, 0);
      chk("mid_count_zero", count, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
